pio_ram_emu_read_streamer: RTL and testbench

//   Streams sequential 16-bit words out of the PIO RAM emulator. Sits upstream of
//   pio_ram_emu_transmitter (issues one read-request message per word) and downstream of
//   pio_ram_emu_receiver (collects returned words). Buffers returned words in a FIFO and

---
 rtl/pio_ram_emu_read_streamer.sv | 177 +++++++++++++++++
 tb/tb_pio_ram_emu_read_streamer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_ram_emu_read_streamer.sv
// pio_ram_emu_read_streamer
//   Streams a burst of sequential 16-bit words out of the PIO RAM emulator. For each word it
//   issues one read-request message toward the transmitter and collects the returned word from
//   the receiver into a small response FIFO. The FIFO is drained on a valid/ready output.
//   Requests are credit-limited (queued + outstanding <= FIFO_DEPTH), so the FIFO cannot
//   overflow however slowly the consumer pops.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start/start_addr/count     burst command (sampled only while idle)
//   busy, err_unexpected       burst in progress; sticky "reply with nothing outstanding"
//   tx_*                       read-request message toward the transmitter
//   rx_data_received, rx_data  returned-word strobe and data from the receiver
//   out_valid/out_data/out_ready  response stream
module pio_ram_emu_read_streamer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [3:0]  READ_HEADER = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] count,
  output logic        busy,
  output logic        err_unexpected,
  input  logic        tx_ready,
  output logic        tx_message_valid,
  output logic [3:0]  tx_header,
  output logic [15:0] tx_data,
  input  logic        tx_message_accepted,
  input  logic        rx_data_received,
  input  logic [15:0] rx_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [CntW:0]   DepthC = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     remaining_q, remaining_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] fifo_count_q, fifo_count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic [CntW:0]   in_use;
  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            drop;
  logic            pop;

  // The accept strobe already encodes the transmitter handshake; tx_ready is informational.
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;

  // Every issued read reserves a FIFO slot until its word is popped.
  assign in_use    = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
  assign credit_ok = (in_use < DepthC);

  assign tx_message_valid = (state_q == StIssue) && credit_ok;
  assign tx_header        = READ_HEADER;
  assign tx_data          = addr_q;

  // Accept without valid is ignored.
  assign accept = tx_message_valid && tx_message_accepted;
  assign push   = rx_data_received && (outstanding_q != '0);
  assign drop   = rx_data_received && (outstanding_q == '0);
  assign pop    = out_valid && out_ready;

  assign busy           = (state_q != StIdle);
  assign err_unexpected = err_q;
  assign out_valid      = (fifo_count_q != '0);
  assign out_data       = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    fifo_count_d  = fifo_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    err_d         = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = count;
          err_d       = 1'b0;
          if (count != 16'd0) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (accept) begin
          addr_d      = addr_q + 16'd1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (outstanding_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A stray reply wins over a same-cycle start clearing the flag.
    if (drop) begin
      err_d = 1'b1;
    end

    // A reply moves one credit from outstanding into the FIFO.
    if (accept && !push) begin
      outstanding_d = outstanding_q + CntOne;
    end else if (!accept && push) begin
      outstanding_d = outstanding_q - CntOne;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CntOne;
    end else if (pop && !push) begin
      fifo_count_d = fifo_count_q - CntOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= 16'd0;
      remaining_q   <= 16'd0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_q         <= err_d;
    end
  end

  // Storage needs no reset: contents are only observed behind fifo_count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

endmodule

// File: tb/tb_pio_ram_emu_read_streamer.sv
module tb_pio_ram_emu_read_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_addr = 16'd0;
  logic [15:0] count = 16'd0;
  logic        busy;
  logic        err_unexpected;
  logic        tx_ready = 1'b1;
  logic        tx_message_valid;
  logic [3:0]  tx_header;
  logic [15:0] tx_data;
  logic        tx_message_accepted;
  logic        rx_data_received;
  logic [15:0] rx_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;

  // Downstream models: auto-responder replies one cycle after each accepted request.
  logic        resp_en = 1'b0;
  logic        resp_strobe = 1'b0;
  logic [15:0] resp_data = 16'd0;
  logic        man_rx = 1'b0;
  logic [15:0] man_data = 16'd0;
  logic [15:0] reply_tab [16];

  logic [15:0] tx_log [256];
  logic [15:0] out_log [256];
  int          tx_n = 0;
  int          out_n = 0;

  int checks = 0;
  int failures = 0;

  assign tx_message_accepted = tx_message_valid & tx_ready;
  assign rx_data_received    = resp_strobe | man_rx;
  assign rx_data             = man_rx ? man_data : resp_data;

  always #5 clk = ~clk;

  pio_ram_emu_read_streamer #(
    .FIFO_DEPTH (4),
    .READ_HEADER(4'h1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .start_addr         (start_addr),
    .count              (count),
    .busy               (busy),
    .err_unexpected     (err_unexpected),
    .tx_ready           (tx_ready),
    .tx_message_valid   (tx_message_valid),
    .tx_header          (tx_header),
    .tx_data            (tx_data),
    .tx_message_accepted(tx_message_accepted),
    .rx_data_received   (rx_data_received),
    .rx_data            (rx_data),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .out_ready          (out_ready)
  );

  always @(posedge clk) begin
    resp_strobe <= 1'b0;
    if (resp_en && tx_message_valid && tx_message_accepted) begin
      resp_strobe <= 1'b1;
      resp_data   <= reply_tab[tx_data[3:0]];
    end
  end

  always @(posedge clk) begin
    if (tx_message_valid && tx_message_accepted && tx_n < 256) begin
      tx_log[tx_n] <= tx_data;
      tx_n         <= tx_n + 1;
    end
    if (out_valid && out_ready && out_n < 256) begin
      out_log[out_n] <= out_data;
      out_n          <= out_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_burst(input logic [15:0] a, input logic [15:0] c);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    count      = c;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic man_reply(input logic [15:0] d);
    @(negedge clk);
    man_rx   = 1'b1;
    man_data = d;
    @(negedge clk);
    man_rx   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while ((busy || out_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy || out_valid) begin
      failures++;
      $display("FAIL %s_timeout: busy=%b out_valid=%b required idle within %0d cycles",
               name, busy, out_valid, budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++;
    if (err_unexpected !== 1'b0) begin
      failures++; $display("FAIL rst_err: got %b want 0", err_unexpected);
    end
    checks++;
    if (tx_message_valid !== 1'b0) begin
      failures++; $display("FAIL rst_txv: got %b want 0", tx_message_valid);
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_outv: got %b want 0", out_valid); end
    checks++;
    if (tx_data !== 16'h0000) begin failures++; $display("FAIL rst_txdata: got %h want 0000", tx_data); end
    checks++;
    if (tx_header !== 4'h1) begin failures++; $display("FAIL rst_header: got %h want 1", tx_header); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    int tb0 = tx_n;
    int ob0 = out_n;
    int k = 0;
    logic [15:0] exp_a [3];
    logic [15:0] exp_d [3];
    exp_a[0] = 16'h0100; exp_a[1] = 16'h0101; exp_a[2] = 16'h0102;
    exp_d[0] = 16'hAAAA; exp_d[1] = 16'hBBBB; exp_d[2] = 16'hCCCC;
    for (int i = 0; i < 3; i++) reply_tab[i] = exp_d[i];
    resp_en   = 1'b1;
    out_ready = 1'b1;
    start_burst(16'h0100, 16'd3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    while (busy && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    checks++;
    if (out_n - ob0 !== 3) begin
      failures++; $display("FAIL basic_words_at_idle: got %0d want 3", out_n - ob0);
    end
    checks++;
    if (tx_n - tb0 !== 3) begin failures++; $display("FAIL basic_req_count: got %0d want 3", tx_n - tb0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[tb0+i] !== exp_a[i]) begin
        failures++; $display("FAIL basic_addr%0d: got %h want %h", i, tx_log[tb0+i], exp_a[i]);
      end
      checks++;
      if (out_log[ob0+i] !== exp_d[i]) begin
        failures++; $display("FAIL basic_data%0d: got %h want %h", i, out_log[ob0+i], exp_d[i]);
      end
    end
  endtask

  task automatic test_credit;
    int tb0 = tx_n;
    int ob0 = out_n;
    for (int i = 0; i < 10; i++) reply_tab[i] = 16'h4000 + 16'(i);
    resp_en   = 1'b1;
    out_ready = 1'b0;
    start_burst(16'h0400, 16'd10);
    tick(12);
    checks++;
    if (tx_n - tb0 !== 4) begin failures++; $display("FAIL credit_stall_reqs: got %0d want 4", tx_n - tb0); end
    checks++;
    if (tx_message_valid !== 1'b0) begin
      failures++; $display("FAIL credit_stall_txv: got %b want 0", tx_message_valid);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h4000) begin
      failures++; $display("FAIL credit_head: got v=%b d=%h want v=1 d=4000", out_valid, out_data);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL credit_busy: got %b want 1", busy); end
    out_ready = 1'b1;
    wait_done(80, "credit");
    checks++;
    if (tx_n - tb0 !== 10) begin failures++; $display("FAIL credit_reqs: got %0d want 10", tx_n - tb0); end
    checks++;
    if (out_n - ob0 !== 10) begin failures++; $display("FAIL credit_words: got %0d want 10", out_n - ob0); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_log[tb0+i] !== 16'h0400 + 16'(i) || out_log[ob0+i] !== 16'h4000 + 16'(i)) begin
        failures++;
        $display("FAIL credit_seq%0d: got a=%h d=%h want a=%h d=%h", i, tx_log[tb0+i],
                 out_log[ob0+i], 16'h0400 + 16'(i), 16'h4000 + 16'(i));
      end
    end
  endtask

  task automatic test_wrap;
    int tb0 = tx_n;
    logic [15:0] exp_a [3];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
    resp_en   = 1'b1;
    out_ready = 1'b1;
    start_burst(16'hFFFE, 16'd3);
    wait_done(20, "wrap");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[tb0+i] !== exp_a[i]) begin
        failures++; $display("FAIL wrap_addr%0d: got %h want %h", i, tx_log[tb0+i], exp_a[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int tb0 = tx_n;
    resp_en   = 1'b1;
    out_ready = 1'b1;
    start_burst(16'h0700, 16'd0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy: got %b want 0", busy); end
    tick(3);
    checks++;
    if (tx_n - tb0 !== 0 || tx_message_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_reqs: got %0d reqs txv=%b want 0 reqs txv=0", tx_n - tb0, tx_message_valid);
    end
    start_burst(16'h0200, 16'd4);
    start_burst(16'h0900, 16'd5);
    wait_done(30, "busy_start");
    checks++;
    if (tx_n - tb0 !== 4) begin failures++; $display("FAIL busy_start_reqs: got %0d want 4", tx_n - tb0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_log[tb0+i] !== 16'h0200 + 16'(i)) begin
        failures++;
        $display("FAIL busy_start_addr%0d: got %h want %h", i, tx_log[tb0+i], 16'h0200 + 16'(i));
      end
    end
    tick(3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle: got %b want 0", busy); end
  endtask

  task automatic test_unexpected;
    int ob0 = out_n;
    resp_en   = 1'b0;
    out_ready = 1'b1;
    man_reply(16'hDEAD);
    checks++;
    if (err_unexpected !== 1'b1) begin
      failures++; $display("FAIL unexp_err: got %b want 1", err_unexpected);
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL unexp_outv: got %b want 0", out_valid); end
    tick(2);
    checks++;
    if (err_unexpected !== 1'b1) begin
      failures++; $display("FAIL unexp_sticky: got %b want 1", err_unexpected);
    end
    reply_tab[0] = 16'h1234;
    resp_en = 1'b1;
    start_burst(16'h0500, 16'd1);
    checks++;
    if (err_unexpected !== 1'b0) begin
      failures++; $display("FAIL unexp_clear: got %b want 0", err_unexpected);
    end
    wait_done(20, "unexp");
    checks++;
    if (out_n - ob0 !== 1 || out_log[ob0] !== 16'h1234) begin
      failures++;
      $display("FAIL unexp_words: got n=%0d d=%h want n=1 d=1234", out_n - ob0, out_log[ob0]);
    end
  endtask

  task automatic test_reset_mid;
    int tb0 = tx_n;
    int k = 0;
    resp_en   = 1'b0;
    out_ready = 1'b0;
    start_burst(16'h0300, 16'd3);
    while (tx_n - tb0 < 3 && k < 10) begin @(negedge clk); k++; end
    checks++;
    if (tx_n - tb0 !== 3) begin failures++; $display("FAIL rmid_reqs: got %0d want 3", tx_n - tb0); end
    man_reply(16'h3333);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3333 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre: got v=%b d=%h busy=%b want v=1 d=3333 busy=1", out_valid, out_data, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || tx_message_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_cleared: got v=%b busy=%b txv=%b want 0 0 0", out_valid, busy,
               tx_message_valid);
    end
    reset = 1'b0;
    tick(1);
    man_reply(16'h4444);
    checks++;
    if (err_unexpected !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_late: got err=%b v=%b want err=1 v=0", err_unexpected, out_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) reply_tab[i] = 16'h0000;
    test_reset();
    test_basic();
    test_credit();
    test_wrap();
    test_ignored_start();
    test_unexpected();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
